// File: rtl/sbox_arbiter.sv
// sbox_arbiter: shares four AES S-box lanes between a 128-bit SubBytes
// requester (four passes of four bytes) and a 32-bit SubWord requester
// (one pass). Each side uses valid/ready handshakes on input and output.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   st_in_valid/st_in_ready/st_in    state request (16 bytes)
//   st_out_valid/st_out_ready/st_out substituted state, held until taken
//   key_in_valid/key_in_ready/key_in key word request (4 bytes)
//   key_out_valid/key_out_ready/key_out substituted word, held until taken
//   busy                             high whenever not IDLE
module sbox_arbiter (
    input  logic         clk,
    input  logic         reset,
    input  logic         st_in_valid,
    output logic         st_in_ready,
    input  logic [127:0] st_in,
    output logic         st_out_valid,
    input  logic         st_out_ready,
    output logic [127:0] st_out,
    input  logic         key_in_valid,
    output logic         key_in_ready,
    input  logic [31:0]  key_in,
    output logic         key_out_valid,
    input  logic         key_out_ready,
    output logic [31:0]  key_out,
    output logic         busy
);

    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 8 * LANES;

    typedef enum logic [2:0] {
        IDLE,
        ST_RUN,
        ST_DONE,
        KEY_RUN,
        KEY_DONE
    } state_t;

    state_t              state;
    logic [1:0]          pass;
    logic                grant_st;   // last grant went to the state requester
    logic [127:0]        st_op;
    logic [31:0]         key_op;
    logic [LANE_W-1:0]   lane_in;
    logic [LANE_W-1:0]   lane_out;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // S-box: multiplicative inverse (x^254, maps 0 to 0) then the affine map
    function automatic logic [7:0] sbox_byte(input logic [7:0] a);
        logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
        x2   = gf_mul(a, a);
        x4   = gf_mul(x2, x2);
        x8   = gf_mul(x4, x4);
        x16  = gf_mul(x8, x8);
        x32  = gf_mul(x16, x16);
        x64  = gf_mul(x32, x32);
        x128 = gf_mul(x64, x64);
        inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                      gf_mul(gf_mul(x32, x64), x128));
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Input readiness: only in IDLE, alternating priority on simultaneous valids
    always_comb begin
        st_in_ready  = 1'b0;
        key_in_ready = 1'b0;
        if (!reset && state == IDLE) begin
            st_in_ready  = !key_in_valid || !grant_st;
            key_in_ready = !st_in_valid  ||  grant_st;
        end
    end

    // Lane operand select: current state pass, otherwise the key word
    always_comb begin
        lane_in = key_op;
        if (state == ST_RUN) begin
            case (pass)
                2'd0:    lane_in = st_op[31:0];
                2'd1:    lane_in = st_op[63:32];
                2'd2:    lane_in = st_op[95:64];
                default: lane_in = st_op[127:96];
            endcase
        end
    end

    // The four shared S-box lanes
    always_comb begin
        lane_out = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_out[8*i +: 8] = sbox_byte(lane_in[8*i +: 8]);
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pass          <= 2'd0;
            grant_st      <= 1'b0;
            st_op         <= '0;
            key_op        <= '0;
            st_out        <= '0;
            key_out       <= '0;
            st_out_valid  <= 1'b0;
            key_out_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (st_in_valid && st_in_ready) begin
                        st_op    <= st_in;
                        pass     <= 2'd0;
                        grant_st <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_RUN;
                    end else if (key_in_valid && key_in_ready) begin
                        key_op   <= key_in;
                        grant_st <= 1'b0;
                        busy     <= 1'b1;
                        state    <= KEY_RUN;
                    end
                end
                ST_RUN: begin
                    case (pass)
                        2'd0:    st_out[31:0]   <= lane_out;
                        2'd1:    st_out[63:32]  <= lane_out;
                        2'd2:    st_out[95:64]  <= lane_out;
                        default: st_out[127:96] <= lane_out;
                    endcase
                    pass <= pass + 2'd1;
                    if (pass == 2'd3) begin
                        st_out_valid <= 1'b1;
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (st_out_ready) begin
                        st_out_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                KEY_RUN: begin
                    key_out       <= lane_out;
                    key_out_valid <= 1'b1;
                    state         <= KEY_DONE;
                end
                KEY_DONE: begin
                    if (key_out_ready) begin
                        key_out_valid <= 1'b0;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_arbiter.sv
// Bench for sbox_arbiter: a transaction-level model (operation kind, cycles
// since accept, table-driven S-box) predicts every output each cycle; directed
// scenarios add literal expectations, then a randomized phase runs.
module tb_sbox_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         st_in_valid, st_in_ready;
    logic [127:0] st_in;
    logic         st_out_valid, st_out_ready;
    logic [127:0] st_out;
    logic         key_in_valid, key_in_ready;
    logic [31:0]  key_in;
    logic         key_out_valid, key_out_ready;
    logic [31:0]  key_out;
    logic         busy;

    always #5 clk = ~clk;

    sbox_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .st_in_valid   (st_in_valid),
        .st_in_ready   (st_in_ready),
        .st_in         (st_in),
        .st_out_valid  (st_out_valid),
        .st_out_ready  (st_out_ready),
        .st_out        (st_out),
        .key_in_valid  (key_in_valid),
        .key_in_ready  (key_in_ready),
        .key_in        (key_in),
        .key_out_valid (key_out_valid),
        .key_out_ready (key_out_ready),
        .key_out       (key_out),
        .busy          (busy)
    );

    logic [0:255][7:0] sbox_t = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: op 0 = none, 1 = state, 2 = key; age = cycles since accept
    int           m_op = 0;
    int           m_age = 0;
    bit           m_last_st = 1'b0;
    logic [127:0] m_st_op, m_st_out;
    logic [31:0]  m_key_op, m_key_out;
    int           grants[$];
    bit           chk_en = 1'b0;

    always @(posedge clk) begin
        chk_en = 1'b1;
        if (reset) begin
            m_op = 0; m_age = 0; m_last_st = 1'b0;
            m_st_out = '0; m_key_out = '0;
        end else begin
            case (m_op)
                0: begin
                    if (st_in_valid && (!key_in_valid || !m_last_st)) begin
                        m_op = 1; m_age = 1; m_st_op = st_in; m_last_st = 1'b1;
                        grants.push_back(1);
                    end else if (key_in_valid && (!st_in_valid || m_last_st)) begin
                        m_op = 2; m_age = 1; m_key_op = key_in; m_last_st = 1'b0;
                        grants.push_back(2);
                    end
                end
                1: begin
                    if (m_age >= 1 && m_age <= 4) begin
                        for (int b = 0; b < 4; b++) begin
                            int idx;
                            idx = 4 * (m_age - 1) + b;
                            m_st_out[8*idx +: 8] = sbox_t[m_st_op[8*idx +: 8]];
                        end
                    end
                    if (m_age >= 5 && st_out_ready) m_op = 0;
                    else m_age++;
                end
                default: begin
                    if (m_age == 1) begin
                        for (int b = 0; b < 4; b++) m_key_out[8*b +: 8] = sbox_t[m_key_op[8*b +: 8]];
                    end
                    if (m_age >= 2 && key_out_ready) m_op = 0;
                    else m_age++;
                end
            endcase
        end
    end

    // Per-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("st_in_ready", st_in_ready, !reset && m_op == 0 && (!key_in_valid || !m_last_st));
            chk("key_in_ready", key_in_ready, !reset && m_op == 0 && (!st_in_valid || m_last_st));
            chk("busy", busy, m_op != 0);
            chk("st_out_valid", st_out_valid, m_op == 1 && m_age >= 5);
            chk("key_out_valid", key_out_valid, m_op == 2 && m_age >= 2);
            chk("st_out", st_out, m_st_out);
            chk("key_out", key_out, m_key_out);
            if (st_in_valid && key_in_valid) chk("ready_exclusive", st_in_ready && key_in_ready, 1'b0);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Issue one state request; returns cycles from accept to st_out_valid
    task automatic run_state(input logic [127:0] d, output int lat);
        bit acc;
        acc = 1'b0;
        st_in = d;
        st_in_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (st_in_ready) acc = 1'b1;
        end
        chk("st_accept", acc, 1'b1);
        step();
        st_in_valid = 1'b0;
        st_in = {$urandom, $urandom, $urandom, $urandom};
        lat = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (st_out_valid) break;
            lat++;
        end
    endtask

    task automatic run_key(input logic [31:0] d, output int lat);
        bit acc;
        acc = 1'b0;
        key_in = d;
        key_in_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (key_in_ready) acc = 1'b1;
        end
        chk("key_accept", acc, 1'b1);
        step();
        key_in_valid = 1'b0;
        key_in = $urandom;
        lat = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (key_out_valid) break;
            lat++;
        end
    endtask

    initial begin
        int           lat;
        int           seen;
        bit           got;
        logic [127:0] held;

        reset = 1'b1;
        st_in_valid = 1'b0; st_in = '0; st_out_ready = 1'b1;
        key_in_valid = 1'b0; key_in = '0; key_out_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_st_out", st_out, 128'h0);
        chk("rst_key_out", key_out, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_st_in_ready", st_in_ready, 1'b0);
        step();
        reset = 1'b0;

        // Single state request of all zeros
        run_state(128'h0, lat);
        chk("st_latency", lat, 5);
        chk("st_zero_result", st_out, {16{8'h63}});
        step();

        // Single key request
        run_key(32'hcf4f3c09, lat);
        chk("key_latency", lat, 2);
        chk("key_result", key_out, 32'h8a84eb01);
        step();

        // Byte i = i checks per-pass placement
        run_state(128'h0f0e0d0c0b0a09080706050403020100, lat);
        chk("mixed_latency", lat, 5);
        chk("mixed_low_word", st_out[31:0], 32'h7b777c63);
        chk("mixed_byte15", st_out[127:120], 8'h76);
        step();

        // Simultaneous valids after reset: state, key, state, key
        reset = 1'b1;
        step();
        step();
        grants.delete();
        reset = 1'b0;
        st_in = {$urandom, $urandom, $urandom, $urandom};
        key_in = $urandom;
        st_in_valid = 1'b1;
        key_in_valid = 1'b1;
        repeat (22) step();
        st_in_valid = 1'b0;
        key_in_valid = 1'b0;
        chk("grant_count", grants.size() >= 4, 1'b1);
        if (grants.size() >= 4) begin
            chk("grant0", grants[0], 1);
            chk("grant1", grants[1], 2);
            chk("grant2", grants[2], 1);
            chk("grant3", grants[3], 2);
        end
        repeat (8) step();

        // Output backpressure with a pending key request
        st_out_ready = 1'b0;
        run_state({$urandom, $urandom, $urandom, $urandom}, lat);
        chk("bp_latency", lat, 5);
        held = st_out;
        step();
        grants.delete();
        key_in = $urandom;
        key_in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid_hold", st_out_valid, 1'b1);
            chk("bp_data_hold", st_out, held);
            chk("bp_st_ready", st_in_ready, 1'b0);
            chk("bp_key_ready", key_in_ready, 1'b0);
        end
        chk("bp_no_early_grant", grants.size(), 0);
        step();
        st_out_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (grants.size() > 0) got = 1'b1;
        end
        key_in_valid = 1'b0;
        chk("bp_key_granted", got, 1'b1);
        if (got) chk("bp_grant_kind", grants[0], 2);
        repeat (6) step();

        // Reset two cycles after a state accept
        st_in = {$urandom, $urandom, $urandom, $urandom};
        st_in_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (st_in_ready) got = 1'b1;
        end
        chk("mid_accept", got, 1'b1);
        step();
        st_in_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_st_out", st_out, 128'h0);
        chk("mid_st_valid", st_out_valid, 1'b0);
        chk("mid_busy", busy, 1'b0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (st_out_valid) seen++;
        end
        chk("mid_no_valid", seen, 0);
        run_state({$urandom, $urandom, $urandom, $urandom}, lat);
        chk("mid_new_latency", lat, 5);
        step();

        // Randomized traffic, occasional reset and backpressure
        repeat (600) begin
            step();
            reset         = ($urandom_range(0, 99) == 0);
            st_in_valid   = $urandom_range(0, 1) == 1;
            key_in_valid  = $urandom_range(0, 1) == 1;
            st_in         = {$urandom, $urandom, $urandom, $urandom};
            key_in        = $urandom;
            st_out_ready  = $urandom_range(0, 3) != 0;
            key_out_ready = $urandom_range(0, 3) != 0;
        end
        reset = 1'b0;
        st_in_valid = 1'b0;
        key_in_valid = 1'b0;
        st_out_ready = 1'b1;
        key_out_ready = 1'b1;
        repeat (10) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
